nes_joypad_hub: RTL and testbench

- Parametrised successor to the single-pad serializer in the NES top level.
- Drives both NES controller ports ($4016/$4017 serial data) from up to four pads, with optional Four Score multiplexing and per-pad turbo on A/B.
- Sits between the openFPGA input mapping and the NES core's `joypad_out` / `joypad_clock` / `joypadN_data` pins.
- Runs entirely in the PPU clock domain.

---
 rtl/nes_input_pkg.sv | 42 ++++
 rtl/nes_turbo_gen.sv | 39 +++
 rtl/nes_joypad_hub.sv | 124 ++++++++++++
 tb/tb_nes_joypad_hub.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_input_pkg.sv
// rtl/nes_input_pkg.sv - shared constants and helpers for the NES joypad hub
//
// Purpose: button bit indices, Four Score signature bytes, shift depth,
// fill constant and the turbo gating helper used by nes_joypad_hub.
// Ports: none (package).

package nes_input_pkg;

  // Button order inside each pad byte: {R,L,D,U,Start,Select,B,A}
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Four Score signature bytes, read LSB first after the two pad bytes
  localparam logic [7:0] FS_SIG_P1 = 8'h08;
  localparam logic [7:0] FS_SIG_P2 = 8'h04;

  localparam int SHIFT_W = 24;

  // Upper 16 bits of a port when only one pad is multiplexed onto it
  localparam logic [15:0] PAD_FILL = 16'hFFFF;

  localparam int TURBO_CNT_W = 4;

  // A/B are only passed while the turbo phase is high, unless turbo is off
  function automatic logic [7:0] apply_turbo(input logic [7:0] btn,
                                             input logic       turbo_a,
                                             input logic       turbo_b,
                                             input logic       phase);
    logic [7:0] res;
    res        = btn;
    res[BTN_A] = btn[BTN_A] & (~turbo_a | phase);
    res[BTN_B] = btn[BTN_B] & (~turbo_b | phase);
    return res;
  endfunction

endpackage

// File: rtl/nes_turbo_gen.sv
// rtl/nes_turbo_gen.sv - per-pad turbo phase generator
//
// Purpose: counts frame_tick pulses and toggles phase every TURBO_FRAMES ticks.
// Ports:
//   clk_ppu_21_47  in   core clock
//   reset_n        in   synchronous active-low reset
//   frame_tick     in   one-cycle pulse per video frame
//   phase          out  turbo phase, 0 after reset

module nes_turbo_gen
  import nes_input_pkg::*;
#(
  parameter int TURBO_FRAMES = 2
) (
  input  logic clk_ppu_21_47,
  input  logic reset_n,
  input  logic frame_tick,
  output logic phase
);

  localparam logic [TURBO_CNT_W-1:0] LAST_COUNT = TURBO_CNT_W'(TURBO_FRAMES - 1);

  logic [TURBO_CNT_W-1:0] count;

  always_ff @(posedge clk_ppu_21_47) begin
    if (!reset_n) begin
      count <= '0;
      phase <= 1'b0;
    end else if (frame_tick) begin
      if (count == LAST_COUNT) begin
        count <= '0;
        phase <= ~phase;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nes_joypad_hub.sv
// rtl/nes_joypad_hub.sv - two-port NES controller serializer with Four Score and turbo
//
// Purpose: loads both controller-port shift registers while the strobe is high
// and shifts one bit per falling edge of the per-port read clock.
// Ports:
//   clk_ppu_21_47  in   core clock
//   reset_n        in   synchronous active-low reset
//   joypad_out     in   strobe bus, bit 0 used
//   joypad_clock   in   per-port read clocks, [0]=port1 [1]=port2
//   pad_buttons    in   8 bits per pad {R,L,D,U,Start,Select,B,A}, pad0 in LSBs
//   turbo_a_en     in   per-pad turbo enable for A
//   turbo_b_en     in   per-pad turbo enable for B
//   four_score_en  in   4-player multiplexing enable
//   mic            in   Famicom microphone bit
//   frame_tick     in   one-cycle pulse per frame
//   joypad1_data   out  {2'b0, mic, 1'b0, serial}
//   joypad2_data   out  {4'b0, serial}

module nes_joypad_hub #(
  parameter int NUM_PADS     = 4,
  parameter int TURBO_FRAMES = 2,
  parameter int SHIFT_W      = 24
) (
  input  logic                  clk_ppu_21_47,
  input  logic                  reset_n,
  input  logic [2:0]            joypad_out,
  input  logic [1:0]            joypad_clock,
  input  logic [8*NUM_PADS-1:0] pad_buttons,
  input  logic [NUM_PADS-1:0]   turbo_a_en,
  input  logic [NUM_PADS-1:0]   turbo_b_en,
  input  logic                  four_score_en,
  input  logic                  mic,
  input  logic                  frame_tick,
  output logic [4:0]            joypad1_data,
  output logic [4:0]            joypad2_data
);

  import nes_input_pkg::*;

  localparam int MAX_PADS = 4;

  // Pads are widened to four slots so the load paths are identical for both builds
  logic [8*MAX_PADS-1:0] pads_ext;
  logic [MAX_PADS-1:0]   ta_ext;
  logic [MAX_PADS-1:0]   tb_ext;
  logic [MAX_PADS-1:0]   phase;
  logic [7:0]            eff [MAX_PADS];
  logic                  fs_active;
  logic                  strobe;
  logic                  strobe_unused;

  logic [SHIFT_W-1:0]    port1_sr;
  logic [SHIFT_W-1:0]    port2_sr;
  logic [SHIFT_W-1:0]    port1_load;
  logic [SHIFT_W-1:0]    port2_load;
  logic [1:0]            last_clock;
  logic [1:0]            fall;

  generate
    if (NUM_PADS == MAX_PADS) begin : g_full
      assign pads_ext = pad_buttons;
      assign ta_ext   = turbo_a_en;
      assign tb_ext   = turbo_b_en;
    end else begin : g_two
      assign pads_ext = {16'h0000, pad_buttons};
      assign ta_ext   = {2'b00, turbo_a_en};
      assign tb_ext   = {2'b00, turbo_b_en};
    end

    for (genvar i = 0; i < MAX_PADS; i++) begin : g_turbo
      if (i < NUM_PADS) begin : g_gen
        nes_turbo_gen #(
          .TURBO_FRAMES (TURBO_FRAMES)
        ) u_turbo (
          .clk_ppu_21_47 (clk_ppu_21_47),
          .reset_n       (reset_n),
          .frame_tick    (frame_tick),
          .phase         (phase[i])
        );
      end else begin : g_tie
        assign phase[i] = 1'b0;
      end
    end
  endgenerate

  assign fs_active     = (NUM_PADS == MAX_PADS) && four_score_en;
  assign strobe        = joypad_out[0];
  assign strobe_unused = &joypad_out[2:1];

  always_comb begin
    for (int i = 0; i < MAX_PADS; i++) begin
      eff[i] = apply_turbo(pads_ext[i*8 +: 8], ta_ext[i], tb_ext[i], phase[i]);
    end
  end

  // Each port carries its own pad first; with Four Score the second pad and
  // the port signature follow, otherwise the tail reads as all ones.
  assign port1_load = fs_active ? {FS_SIG_P1, eff[2], eff[0]} : {PAD_FILL, eff[0]};
  assign port2_load = fs_active ? {FS_SIG_P2, eff[3], eff[1]} : {PAD_FILL, eff[1]};

  assign fall = last_clock & ~joypad_clock;

  always_ff @(posedge clk_ppu_21_47) begin
    if (!reset_n) begin
      port1_sr   <= '0;
      port2_sr   <= '0;
      last_clock <= 2'b00;
    end else begin
      last_clock <= joypad_clock;
      if (strobe) begin
        // Strobe has priority over any coincident read-clock edge
        port1_sr <= port1_load;
        port2_sr <= port2_load;
      end else begin
        if (fall[0]) port1_sr <= {1'b1, port1_sr[SHIFT_W-1:1]};
        if (fall[1]) port2_sr <= {1'b1, port2_sr[SHIFT_W-1:1]};
      end
    end
  end

  assign joypad1_data = {2'b00, mic, 1'b0, port1_sr[0]};
  assign joypad2_data = {4'b0000, port2_sr[0]};

endmodule

// File: tb/tb_nes_joypad_hub.sv
// tb/tb_nes_joypad_hub.sv - scoreboard bench for nes_joypad_hub (4-pad and 2-pad builds)

module tb_nes_joypad_hub;

  localparam int TF = 2;

  typedef struct packed {
    logic [7:0]  test;
    logic [15:0] idx;
    logic        dut;
    logic        port;
    logic [4:0]  exp;
  } rec_t;

  logic       clk;
  logic       reset_n;
  logic [2:0] joypad_out;
  logic [1:0] joypad_clock;
  logic [3:0] ta;
  logic [3:0] tb;
  logic       fs;
  logic       mic;
  logic       frame_tick;
  logic [7:0] pads [4];
  logic [31:0] pb4;
  logic [15:0] pb2;
  logic [4:0] d4_j1, d4_j2, d2_j1, d2_j2;

  rec_t sb[$];
  bit   mq [0:3][$];
  logic mon_take;
  int   ticks;
  int   cur_test;
  int   sample_idx;
  int   checks;
  int   failures;

  assign pb4 = {pads[3], pads[2], pads[1], pads[0]};
  assign pb2 = {pads[1], pads[0]};

  nes_joypad_hub #(.NUM_PADS(4), .TURBO_FRAMES(TF), .SHIFT_W(24)) d4 (
    .clk_ppu_21_47 (clk),
    .reset_n       (reset_n),
    .joypad_out    (joypad_out),
    .joypad_clock  (joypad_clock),
    .pad_buttons   (pb4),
    .turbo_a_en    (ta),
    .turbo_b_en    (tb),
    .four_score_en (fs),
    .mic           (mic),
    .frame_tick    (frame_tick),
    .joypad1_data  (d4_j1),
    .joypad2_data  (d4_j2)
  );

  nes_joypad_hub #(.NUM_PADS(2), .TURBO_FRAMES(TF), .SHIFT_W(24)) d2 (
    .clk_ppu_21_47 (clk),
    .reset_n       (reset_n),
    .joypad_out    (joypad_out),
    .joypad_clock  (joypad_clock),
    .pad_buttons   (pb2),
    .turbo_a_en    (ta[1:0]),
    .turbo_b_en    (tb[1:0]),
    .four_score_en (fs),
    .mic           (mic),
    .frame_tick    (frame_tick),
    .joypad1_data  (d2_j1),
    .joypad2_data  (d2_j2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit, got running exp finished");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (mon_take) begin
      while (sb.size() > 0) begin
        rec_t r;
        logic [4:0] act;
        r = sb.pop_front();
        if (!r.dut) act = r.port ? d4_j2 : d4_j1;
        else        act = r.port ? d2_j2 : d2_j1;
        checks++;
        if (act !== r.exp) begin
          failures++;
          $display("FAIL test%0d sample%0d dut%0d port%0d got=%b exp=%b",
                   r.test, r.idx, r.dut ? 2 : 4, r.port + 1, act, r.exp);
        end
      end
    end
  end

  function automatic logic [7:0] eff_m(int d, int p);
    logic [7:0] b;
    bit ph;
    if (d == 1 && p >= 2) return 8'h00;
    b  = pads[p];
    ph = ((ticks / TF) % 2) == 1;
    if (ta[p] && !ph) b[0] = 1'b0;
    if (tb[p] && !ph) b[1] = 1'b0;
    return b;
  endfunction

  task automatic model_load();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        logic [7:0] bytes [3];
        bit fs_d;
        int k;
        k = d * 2 + p;
        fs_d = fs && (d == 0);
        bytes[0] = eff_m(d, p);
        bytes[1] = fs_d ? eff_m(d, p + 2) : 8'hFF;
        bytes[2] = fs_d ? ((p == 0) ? 8'h08 : 8'h04) : 8'hFF;
        mq[k].delete();
        for (int by = 0; by < 3; by++)
          for (int bi = 0; bi < 8; bi++) mq[k].push_back(bytes[by][bi]);
      end
    end
  endtask

  task automatic model_reset();
    ticks = 0;
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      for (int i = 0; i < 24; i++) mq[k].push_back(1'b0);
    end
  endtask

  function automatic bit exp_bit(int k);
    return (mq[k].size() > 0) ? mq[k][0] : 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_all();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        rec_t r;
        bit b;
        b = exp_bit(d * 2 + p);
        r.test = 8'(cur_test);
        r.idx  = 16'(sample_idx);
        r.dut  = d[0];
        r.port = p[0];
        r.exp  = (p == 0) ? {2'b00, mic, 1'b0, b} : {4'b0000, b};
        sb.push_back(r);
      end
    end
    sample_idx++;
    mon_take = 1'b1;
    tick();
    mon_take = 1'b0;
  endtask

  task automatic strobe_on();
    joypad_out = 3'b001;
    tick();
    model_load();
  endtask

  task automatic strobe_off();
    joypad_out = 3'b000;
    tick();
  endtask

  task automatic pulse(input logic [1:0] mask);
    joypad_clock = joypad_clock | mask;
    tick();
    joypad_clock = joypad_clock & ~mask;
    tick();
    if (!joypad_out[0]) begin
      for (int p = 0; p < 2; p++) begin
        if (mask[p]) begin
          if (mq[p].size() > 0) void'(mq[p].pop_front());
          if (mq[2 + p].size() > 0) void'(mq[2 + p].pop_front());
        end
      end
    end
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    ticks++;
  endtask

  task automatic do_reset();
    mic = 1'b0;
    reset_n = 1'b0;
    tick();
    model_reset();
    sample_all();
    reset_n = 1'b1;
  endtask

  task automatic new_test(input int t);
    cur_test = t;
    sample_idx = 0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    mon_take = 1'b0;
    reset_n = 1'b0;
    joypad_out = 3'b000;
    joypad_clock = 2'b00;
    ta = 4'h0;
    tb = 4'h0;
    fs = 1'b0;
    mic = 1'b0;
    frame_tick = 1'b0;
    for (int i = 0; i < 4; i++) pads[i] = 8'h00;
    ticks = 0;
    tick();
    tick();

    new_test(1);
    do_reset();
    checks++;
    if (d4_j1 !== 5'b00000 || d4_j2 !== 5'b00000 ||
        d2_j1 !== 5'b00000 || d2_j2 !== 5'b00000) begin
      failures++;
      $display("FAIL test1 direct reset got=%b %b %b %b exp=00000",
               d4_j1, d4_j2, d2_j1, d2_j2);
    end

    new_test(2);
    pads[0] = 8'h81;
    pads[1] = 8'h3C;
    strobe_on();
    strobe_off();
    for (int i = 0; i < 24; i++) begin
      sample_all();
      pulse(2'b11);
    end
    sample_all();
    checks++;
    if (d4_j1 !== 5'b00001 || d2_j1 !== 5'b00001) begin
      failures++;
      $display("FAIL test2 direct 25th read got=%b %b exp=00001", d4_j1, d2_j1);
    end

    new_test(3);
    fs = 1'b1;
    pads[0] = 8'h01; pads[1] = 8'h02; pads[2] = 8'h80; pads[3] = 8'h40;
    strobe_on();
    strobe_off();
    for (int i = 0; i < 24; i++) begin
      sample_all();
      pulse(2'b11);
    end
    sample_all();
    fs = 1'b0;

    new_test(4);
    do_reset();
    pads[0] = 8'h01;
    ta = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      frame();
      strobe_on();
      strobe_off();
      sample_all();
    end
    ta = 4'h0;

    new_test(5);
    pads[0] = 8'h01;
    strobe_on();
    pulse(2'b01);
    sample_all();
    strobe_off();
    sample_all();
    pulse(2'b01);
    sample_all();

    new_test(6);
    pads[0] = 8'hA5;
    pads[1] = 8'h5A;
    strobe_on();
    strobe_off();
    for (int i = 0; i < 3; i++) pulse(2'b01);
    do_reset();
    sample_all();
    strobe_on();
    strobe_off();
    sample_all();

    new_test(7);
    for (int it = 0; it < 300; it++) begin
      int op;
      op = $urandom_range(0, 8);
      case (op)
        0: begin
          for (int i = 0; i < 4; i++) pads[i] = 8'($urandom);
          ta  = 4'($urandom);
          tb  = 4'($urandom);
          fs  = 1'($urandom);
          mic = 1'($urandom);
        end
        1: begin
          strobe_on();
          if ($urandom_range(0, 1) == 1) pulse(2'($urandom_range(1, 3)));
          strobe_off();
        end
        2: pulse(2'b01);
        3: pulse(2'b10);
        4: pulse(2'b11);
        5: frame();
        6: mic = ~mic;
        7: if ($urandom_range(0, 15) == 0) do_reset();
        default: tick();
      endcase
      sample_all();
    end

    tick();
    if (failures != 0) $display("FAIL summary failures=%0d", failures);
    else               $display("PASS");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
